// File: rtl/window_gen_3x3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_3x3_pkg
//  Description : Shared definitions for the 3x3 window generator: pixel and
//                window widths, the FSM state type, the byte-lane offsets of
//                the nine window positions and a window packing helper.
//                Lane naming: t/m/b = top/middle/bottom row (r-2/r-1/r),
//                l/m/r = left/middle/right column (c-2/c-1/c).
//  Revision    : 1.0 - initial release
// ============================================================================
package window_gen_3x3_pkg;

  localparam int unsigned c_pix_w = 8;
  localparam int unsigned c_win_w = 72;

  // Byte-lane offsets inside window_out. The bottom row sits in the top
  // bytes, followed by the middle row, then the top row.
  localparam int unsigned c_ofs_tl = 16;  // (r-2, c-2)
  localparam int unsigned c_ofs_tm = 8;   // (r-2, c-1)
  localparam int unsigned c_ofs_tr = 0;   // (r-2, c)
  localparam int unsigned c_ofs_ml = 40;  // (r-1, c-2)
  localparam int unsigned c_ofs_mm = 32;  // (r-1, c-1) centre
  localparam int unsigned c_ofs_mr = 24;  // (r-1, c)
  localparam int unsigned c_ofs_bl = 64;  // (r,   c-2)
  localparam int unsigned c_ofs_bm = 56;  // (r,   c-1)
  localparam int unsigned c_ofs_br = 48;  // (r,   c)

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,  // rows 0-1: line buffers are priming
    ST_RUN  = 1'b1   // rows 2..last: windows may be emitted
  } state_e;

  function automatic logic [c_win_w-1:0] pack_window(
    input logic [c_pix_w-1:0] tl, input logic [c_pix_w-1:0] tm, input logic [c_pix_w-1:0] tr,
    input logic [c_pix_w-1:0] ml, input logic [c_pix_w-1:0] mm, input logic [c_pix_w-1:0] mr,
    input logic [c_pix_w-1:0] bl, input logic [c_pix_w-1:0] bm, input logic [c_pix_w-1:0] br
  );
    logic [c_win_w-1:0] w;
    w = '0;
    w[c_ofs_tl +: c_pix_w] = tl;
    w[c_ofs_tm +: c_pix_w] = tm;
    w[c_ofs_tr +: c_pix_w] = tr;
    w[c_ofs_ml +: c_pix_w] = ml;
    w[c_ofs_mm +: c_pix_w] = mm;
    w[c_ofs_mr +: c_pix_w] = mr;
    w[c_ofs_bl +: c_pix_w] = bl;
    w[c_ofs_bm +: c_pix_w] = bm;
    w[c_ofs_br +: c_pix_w] = br;
    return w;
  endfunction

endpackage : window_gen_3x3_pkg
`default_nettype wire

// File: rtl/window_gen_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : DEPTH-stage, 8-bit delay line advancing only when en_i is
//                high. The value on dout_o while a sample is presented on
//                din_i is the sample presented DEPTH advances earlier.
//                Storage is DEPTH-1 RAM entries plus the output register.
//                Storage is not cleared by reset.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset (pointer only)
//                en_i   - advance enable
//                din_i  - sample in
//                dout_o - registered delayed sample out
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [c_pix_w-1:0] din_i,
  output logic [c_pix_w-1:0] dout_o
);

  localparam int MEM_D = DEPTH - 1;
  localparam int PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  logic [c_pix_w-1:0] mem_q [MEM_D];
  logic [c_pix_w-1:0] dout_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(MEM_D - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Read-before-write on the same entry: the oldest sample moves into the
  // output register as the newest one takes its slot.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
      dout_q       <= mem_q[ptr_q];
    end
  end

  assign dout_o = dout_q;

endmodule : line_buffer
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_3x3
//  Description : Builds 3x3 pixel windows from a raster-order pixel stream
//                using two line buffers and three column shift registers.
//                A window is emitted one cycle after each accepted pixel at
//                row >= 2 and column >= 2, so windows never straddle rows or
//                frames. Optional frame_done output is enabled by defining
//                WINDOW_GEN_3X3_FRAME_DONE_EN.
//  Ports       : clk              - rising-edge clock
//                reset            - synchronous active-high reset
//                pixel_in         - 8-bit raster pixel
//                pixel_in_valid   - pixel accepted this cycle (no backpressure)
//                window_out       - 72-bit packed 3x3 window
//                window_out_valid - new window this cycle
//                frame_done       - (optional) pulses with last window of frame
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [c_pix_w-1:0] pixel_in,
  input  logic               pixel_in_valid,
  output logic [c_win_w-1:0] window_out,
  output logic               window_out_valid
`ifdef WINDOW_GEN_3X3_FRAME_DONE_EN
  ,
  output logic               frame_done
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic w_accept;
  logic w_col_last;
  logic w_row_last;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  state_e           state_q, state_d;

  // Older two taps of each 3-tap column register; the newest tap is the live
  // input (pixel_in / line-buffer output), giving 1-cycle window latency.
  logic [1:0][c_pix_w-1:0] bot_q, bot_d;
  logic [1:0][c_pix_w-1:0] mid_q, mid_d;
  logic [1:0][c_pix_w-1:0] top_q, top_d;

  logic [c_pix_w-1:0] w_lb1_out;  // pixel (r-1, c)
  logic [c_pix_w-1:0] w_lb2_out;  // pixel (r-2, c)

  logic [c_win_w-1:0] win_q, win_d;
  logic               valid_q, valid_d;

  // A pixel presented during reset is never accepted.
  assign w_accept   = pixel_in_valid & ~reset;
  assign w_col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk    (clk),
    .reset  (reset),
    .en_i   (w_accept),
    .din_i  (pixel_in),
    .dout_o (w_lb1_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk    (clk),
    .reset  (reset),
    .en_i   (w_accept),
    .din_i  (w_lb1_out),
    .dout_o (w_lb2_out)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    bot_d   = bot_q;
    mid_d   = mid_q;
    top_d   = top_q;
    valid_d = 1'b0;
    win_d   = win_q;

    if (w_accept) begin
      col_d = w_col_last ? '0 : col_q + 1'b1;
      if (w_col_last) begin
        row_d = w_row_last ? '0 : row_q + 1'b1;
      end
      bot_d = {bot_q[0], pixel_in};
      mid_d = {mid_q[0], w_lb1_out};
      top_d = {top_q[0], w_lb2_out};
    end

    case (state_q)
      ST_FILL: if (w_accept && w_col_last && (row_q == ROW_W'(1))) state_d = ST_RUN;
      ST_RUN:  if (w_accept && w_col_last && w_row_last)           state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase

    // RUN guarantees both line buffers hold rows of the current frame;
    // col >= 2 guarantees all column taps come from the current row.
    valid_d = w_accept && (state_q == ST_RUN) && (col_q >= COL_W'(2));
    if (valid_d) begin
      win_d = pack_window(top_q[1], top_q[0], w_lb2_out,
                          mid_q[1], mid_q[0], w_lb1_out,
                          bot_q[1], bot_q[0], pixel_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= ST_FILL;
      bot_q   <= '0;
      mid_q   <= '0;
      top_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      bot_q   <= bot_d;
      mid_q   <= mid_d;
      top_q   <= top_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign window_out       = win_q;
  assign window_out_valid = valid_q;

`ifdef WINDOW_GEN_3X3_FRAME_DONE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= valid_d && w_col_last && w_row_last;
    end
  end

  assign frame_done = done_q;
`endif

endmodule : window_gen_3x3
`default_nettype wire
